// File: rtl/arith_scoreboard.sv
// arith_scoreboard: latency-aligned reference checker that snoops an arithmetic DUT and scores its results.
// Latency: a sample taken at T is compared at T+DUT_LAT; event, counters and capture change at T+DUT_LAT+1.
// Backpressure: none. It accepts one sample per cycle and the delay line never stalls.
module arith_scoreboard #(
  parameter int WIDTH     = 32,
  parameter int DUT_LAT   = 2,
  parameter int MODE      = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_en,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_dut_ia,
  input  logic [WIDTH-1:0]     i_dut_ib,
  input  logic [WIDTH-1:0]     i_dut_os,
  input  logic [WIDTH-1:0]     i_cmp_mask,
  output logic                 o_ready,
  output logic                 o_event,
  output logic                 o_err_sticky,
  output logic [CNT_WIDTH-1:0] o_chk_cnt,
  output logic [CNT_WIDTH-1:0] o_err_cnt,
  output logic [CNT_WIDTH-1:0] o_first_idx,
  output logic [WIDTH-1:0]     o_first_a,
  output logic [WIDTH-1:0]     o_first_b,
  output logic [WIDTH-1:0]     o_first_dut,
  output logic [WIDTH-1:0]     o_first_exp
);

  // The warm-up counter must be able to hold DUT_LAT+1.
  localparam int                   WU_W    = $clog2(DUT_LAT + 2);
  localparam logic [WU_W-1:0]      WU_DONE = WU_W'(DUT_LAT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] idx;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     dut;
    logic [WIDTH-1:0]     exp;
  } cap_t;

  logic [WU_W-1:0]             wu_q, wu_d;
  stage_t [DUT_LAT-1:0]        line_q, line_d;
  logic [CNT_WIDTH-1:0]        chk_q, chk_d, err_q, err_d;
  logic                        sticky_q, sticky_d, event_q, event_d;
  cap_t                        cap_q, cap_d;
  logic                        ready_pre;
  stage_t                      tap;
  logic [WIDTH-1:0]            exp_val;
  logic                        mis;

  // Unsigned reference op; all results wrap mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (MODE)
      1:       r = a - b;
      2:       r = a * b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign ready_pre = (wu_q == WU_DONE);
  assign tap       = line_q[DUT_LAT-1];
  assign exp_val   = ref_op(tap.a, tap.b);
  assign mis       = |((i_dut_os ^ exp_val) & i_cmp_mask);

  // Warm-up counts up after reset and holds once the line is known to be flushed.
  always_comb begin
    wu_d = wu_q;
    if (!ready_pre) wu_d = wu_q + 1'b1;
  end

  // Delay line: stage 0 only admits enabled samples after warm-up, then shifts every cycle.
  always_comb begin
    line_d = line_q;
    line_d[0].vld = i_valid & i_en & ready_pre;
    line_d[0].a   = i_dut_ia;
    line_d[0].b   = i_dut_ib;
    for (int k = 1; k < DUT_LAT; k++) line_d[k] = line_q[k-1];
  end

  // Statistics: clear beats a coincident compare; the first mismatch context is frozen by sticky.
  always_comb begin
    chk_d    = chk_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    event_d  = 1'b0;
    cap_d    = cap_q;
    if (i_clear) begin
      chk_d    = '0;
      err_d    = '0;
      sticky_d = 1'b0;
      cap_d    = '0;
    end else if (tap.vld) begin
      if (chk_q != CNT_MAX) chk_d = chk_q + 1'b1;
      if (mis) begin
        event_d  = 1'b1;
        sticky_d = 1'b1;
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        if (!sticky_q) begin
          cap_d.idx = chk_q;
          cap_d.a   = tap.a;
          cap_d.b   = tap.b;
          cap_d.dut = i_dut_os;
          cap_d.exp = exp_val;
        end
      end
    end
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wu_q   <= '0;
      line_q <= '0;
    end else begin
      wu_q   <= wu_d;
      line_q <= line_d;
    end
  end

  // Statistics and capture registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chk_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
      event_q  <= 1'b0;
      cap_q    <= '0;
    end else begin
      chk_q    <= chk_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      event_q  <= event_d;
      cap_q    <= cap_d;
    end
  end

  assign o_ready      = ready_pre;
  assign o_event      = event_q;
  assign o_err_sticky = sticky_q;
  assign o_chk_cnt    = chk_q;
  assign o_err_cnt    = err_q;
  assign o_first_idx  = cap_q.idx;
  assign o_first_a    = cap_q.a;
  assign o_first_b    = cap_q.b;
  assign o_first_dut  = cap_q.dut;
  assign o_first_exp  = cap_q.exp;

endmodule

// File: tb/tb_arith_scoreboard.sv
// Bench for arith_scoreboard: three instances (add, sub, mul) share one stimulus stream.
// A fake DUT per instance returns the true result XOR an injected error pattern.
// A queue-based model of the checking rules is compared against every output each cycle.
module tb_arith_scoreboard;
  localparam int W  = 8;
  localparam int L  = 2;
  localparam int CW = 4;
  localparam int unsigned MOD = 1 << W;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0, en = 1'b1, clr = 1'b0, vld = 1'b0;
  logic [W-1:0] ia = '0, ib = '0, inj = '0, mask = 8'hFF;
  logic [W-1:0] os [3];
  logic         rdy [3], evt [3], stk [3];
  logic [CW-1:0] chk [3], err [3], fidx [3];
  logic [W-1:0] fa [3], fb [3], fdut [3], fexp [3];

  int checks = 0, fails = 0, ev_cnt = 0;

  function automatic int unsigned ref_f(input int m, input int unsigned a, input int unsigned b);
    case (m)
      1:       return (a + MOD - b) % MOD;
      2:       return (a * b) % MOD;
      default: return (a + b) % MOD;
    endcase
  endfunction

  // Fake DUTs with the same latency as the checker expects.
  logic [W-1:0] pipe [3][L];
  always @(posedge clk) begin
    for (int m = 0; m < 3; m++) begin
      pipe[m][0] <= W'(ref_f(m, ia, ib)) ^ inj;
      for (int k = 1; k < L; k++) pipe[m][k] <= pipe[m][k-1];
    end
  end

  for (genvar m = 0; m < 3; m++) begin : g_dut
    assign os[m] = pipe[m][L-1];
    arith_scoreboard #(.WIDTH(W), .DUT_LAT(L), .MODE(m), .CNT_WIDTH(CW)) u_dut (
      .clk(clk), .reset_n(reset_n), .i_en(en), .i_clear(clr), .i_valid(vld),
      .i_dut_ia(ia), .i_dut_ib(ib), .i_dut_os(os[m]), .i_cmp_mask(mask),
      .o_ready(rdy[m]), .o_event(evt[m]), .o_err_sticky(stk[m]),
      .o_chk_cnt(chk[m]), .o_err_cnt(err[m]), .o_first_idx(fidx[m]),
      .o_first_a(fa[m]), .o_first_b(fb[m]), .o_first_dut(fdut[m]), .o_first_exp(fexp[m]));
  end

  // Reference model: queue of accepted samples, each due for comparison L cycles later.
  typedef struct {int due; int a; int b; int inj;} smp_t;
  smp_t q[$];
  int cyc = 0, since_rst = 0;
  int m_chk = 0, m_err = 0, m_fidx = 0, m_fa = 0, m_fb = 0;
  bit m_sticky = 0, m_event = 0, m_ready = 0;
  int m_fdut [3], m_fexp [3];

  task automatic model_clear_stats();
    m_chk = 0; m_err = 0; m_sticky = 0; m_fidx = 0; m_fa = 0; m_fb = 0;
    for (int m = 0; m < 3; m++) begin m_fdut[m] = 0; m_fexp[m] = 0; end
  endtask

  task automatic model_step();
    smp_t s;
    bit cmp, mis;
    cmp = 0; mis = 0;
    if (!reset_n) begin
      q.delete();
      since_rst = 0;
      m_event = 0;
      model_clear_stats();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        s = q.pop_front();
        cmp = 1;
        mis = ((s.inj & int'(mask)) != 0);
      end
      if (vld && en && since_rst >= L + 1) begin
        smp_t n;
        n.due = cyc + L; n.a = int'(ia); n.b = int'(ib); n.inj = int'(inj);
        q.push_back(n);
      end
      if (since_rst < L + 1) since_rst++;
      m_event = 0;
      if (clr) model_clear_stats();
      else if (cmp) begin
        if (mis && !m_sticky) begin
          m_fidx = m_chk; m_fa = s.a; m_fb = s.b;
          for (int m = 0; m < 3; m++) begin
            m_fexp[m] = int'(ref_f(m, s.a, s.b));
            m_fdut[m] = m_fexp[m] ^ s.inj;
          end
        end
        if (mis) begin
          m_event = 1; m_sticky = 1;
          if (m_err < CMAX) m_err++;
        end
        if (m_chk < CMAX) m_chk++;
      end
    end
    m_ready = (since_rst >= L + 1);
    cyc++;
  endtask

  task automatic chk_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk_eq($sformatf("ready[%0d]", m), int'(rdy[m]), int'(m_ready));
      chk_eq($sformatf("event[%0d]", m), int'(evt[m]), int'(m_event));
      chk_eq($sformatf("sticky[%0d]", m), int'(stk[m]), int'(m_sticky));
      chk_eq($sformatf("chk_cnt[%0d]", m), int'(chk[m]), m_chk);
      chk_eq($sformatf("err_cnt[%0d]", m), int'(err[m]), m_err);
      chk_eq($sformatf("first_idx[%0d]", m), int'(fidx[m]), m_fidx);
      chk_eq($sformatf("first_a[%0d]", m), int'(fa[m]), m_fa);
      chk_eq($sformatf("first_b[%0d]", m), int'(fb[m]), m_fb);
      chk_eq($sformatf("first_dut[%0d]", m), int'(fdut[m]), m_fdut[m]);
      chk_eq($sformatf("first_exp[%0d]", m), int'(fexp[m]), m_fexp[m]);
    end
    if (evt[0]) ev_cnt++;
  endtask

  // One clock: drive inputs, advance the model, sample on the falling edge.
  task automatic step(input bit r_n, input bit v, input bit e, input bit c,
                      input int a, input int b, input int ij);
    reset_n = r_n; vld = v; en = e; clr = c;
    ia = W'(a); ib = W'(b); inj = W'(ij);
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic send(input int a, input int b, input int ij);
    step(1, 1, 1, 0, a, b, ij);
  endtask

  task automatic clear_pulse();
    step(1, 0, 1, 1, 0, 0, 0);
  endtask

  typedef struct {
    logic [W-1:0] a; logic [W-1:0] b;
    logic [W-1:0] e_add; logic [W-1:0] e_sub; logic [W-1:0] e_mul;
  } op_vec_t;
  op_vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev0;
    logic [W-1:0] t;
    tbl[0] = '{8'h03, 8'h05, 8'h08, 8'hFE, 8'h0F};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 8'hFE, 8'hFF};
    tbl[2] = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'h10, 8'h20, 8'h30, 8'hF0, 8'h00};
    tbl[4] = '{8'h0F, 8'h11, 8'h20, 8'hFE, 8'hFF};
    tbl[5] = '{8'hC8, 8'h07, 8'hCF, 8'hC1, 8'h78};

    // Reset held 3 cycles with valid active; then warm-up and a clean stream.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 9, 9, 8'hFF);
      chk_eq("reset_ready", int'(rdy[0]), 0);
      chk_eq("reset_chk", int'(chk[0]), 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 100 + i, 1, 8'hFF);
      chk_eq($sformatf("warmup_ready_%0d", i), int'(rdy[0]), (i == 2) ? 1 : 0);
    end
    ev0 = ev_cnt;
    for (int i = 1; i <= 10; i++) send(i, 2 * i, 0);
    idle(L);
    chk_eq("clean_chk_cnt", int'(chk[0]), 10);
    chk_eq("clean_err_cnt", int'(err[0]), 0);
    chk_eq("clean_events", ev_cnt - ev0, 0);

    // First-error capture with a second, later mismatch.
    clear_pulse();
    send(1, 1, 0);
    send(2, 3, 0);
    send(8'hFF, 8'h02, 8'h03);
    send(4, 4, 0);
    send(5, 5, 8'h80);
    chk_eq("first_err_event_s3", int'(evt[0]), 1);
    idle(1);
    chk_eq("first_err_gap", int'(evt[0]), 0);
    idle(1);
    chk_eq("first_err_event_s5", int'(evt[0]), 1);
    chk_eq("first_err_cnt", int'(err[0]), 2);
    chk_eq("first_err_idx", int'(fidx[0]), 2);
    chk_eq("first_err_a", int'(fa[0]), 8'hFF);
    chk_eq("first_err_b", int'(fb[0]), 8'h02);
    chk_eq("first_err_dut", int'(fdut[0]), 8'h02);
    chk_eq("first_err_exp", int'(fexp[0]), 8'h01);

    // Mask on the subtractor: LSB-only error hidden, then visible.
    clear_pulse();
    mask = 8'hFE;
    send(8'h10, 8'h20, 8'h01);
    idle(L);
    chk_eq("mask_hidden_err", int'(err[1]), 0);
    chk_eq("mask_hidden_chk", int'(chk[1]), 1);
    mask = 8'hFF;
    send(8'h10, 8'h20, 8'h01);
    idle(L);
    chk_eq("mask_seen_event", int'(evt[1]), 1);
    chk_eq("mask_seen_dut", int'(fdut[1]), 8'hF1);
    chk_eq("mask_seen_exp", int'(fexp[1]), 8'hF0);

    // Clear coinciding with a mismatching compare.
    clear_pulse();
    send(1, 1, 0);
    send(2, 2, 0);
    send(3, 3, 8'hFF);
    idle(1);
    clear_pulse();
    chk_eq("collide_event", int'(evt[0]), 0);
    chk_eq("collide_chk", int'(chk[0]), 0);
    chk_eq("collide_err", int'(err[0]), 0);
    chk_eq("collide_sticky", int'(stk[0]), 0);
    send(7, 9, 8'h0F);
    idle(L);
    chk_eq("collide_next_err", int'(err[0]), 1);
    chk_eq("collide_next_idx", int'(fidx[0]), 0);
    chk_eq("collide_next_a", int'(fa[0]), 7);

    // Saturation of both counters, then reset with two samples in flight.
    clear_pulse();
    ev0 = ev_cnt;
    for (int i = 0; i < 20; i++) send(i, i + 1, 8'hFF);
    idle(L);
    chk_eq("sat_err_cnt", int'(err[0]), 15);
    chk_eq("sat_chk_cnt", int'(chk[0]), 15);
    chk_eq("sat_last_event", int'(evt[0]), 1);
    chk_eq("sat_event_count", ev_cnt - ev0, 20);
    send(1, 1, 8'hFF);
    send(2, 2, 8'hFF);
    ev0 = ev_cnt;
    step(0, 0, 1, 0, 0, 0, 0);
    chk_eq("midrst_err", int'(err[0]), 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk_eq($sformatf("midrst_ready_%0d", i), int'(rdy[0]), (i == 2) ? 1 : 0);
    end
    idle(L);
    chk_eq("midrst_events", ev_cnt - ev0, 0);
    chk_eq("midrst_chk", int'(chk[0]), 0);

    // Operator table: force a full-byte mismatch and read back the captured expectation.
    for (int i = 0; i < 6; i++) begin
      clear_pulse();
      send(int'(tbl[i].a), int'(tbl[i].b), 8'hFF);
      idle(L);
      chk_eq($sformatf("op%0d_add_exp", i), int'(fexp[0]), int'(tbl[i].e_add));
      chk_eq($sformatf("op%0d_sub_exp", i), int'(fexp[1]), int'(tbl[i].e_sub));
      chk_eq($sformatf("op%0d_mul_exp", i), int'(fexp[2]), int'(tbl[i].e_mul));
      t = ~tbl[i].e_mul;
      chk_eq($sformatf("op%0d_mul_dut", i), int'(fdut[2]), int'(t));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      if ($urandom_range(0, 15) == 0) begin
        sel = $urandom_range(0, 3);
        mask = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : (sel == 2) ? 8'hFE : W'($urandom);
      end
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 49) == 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/arith_scoreboard.md
Name: arith_scoreboard

Overview:
- Next-generation self-checking monitor for the arithmetic testbench. It replaces round-robin sub-monitors on derived clocks with one fully synchronous, latency-aligned reference pipeline.
- Inputs are valid-qualified. Comparison is bit-masked. The block keeps saturating check and error counters and captures the full context of the first mismatch.
- It sits beside the DUT and snoops operands and result. Its outputs feed the bench status and error-logging logic.

Parameters:
- WIDTH, 32: operand and result width.
- DUT_LAT, 2: DUT latency in cycles from operand valid to result; legal range 1..16.
- MODE, 0: reference op; 0 = a+b, 1 = a-b, 2 = a*b (low WIDTH bits), others treated as 0; all ops mod 2^WIDTH.
- CNT_WIDTH, 16: width of the check and error counters.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- i_en  in  1  checking enable, sampled with i_valid.
- i_clear  in  1  one-cycle pulse; clears statistics and capture.
- i_valid  in  1  operands on i_dut_ia/i_dut_ib are valid this cycle.
- i_dut_ia  in  WIDTH  DUT operand a.
- i_dut_ib  in  WIDTH  DUT operand b.
- i_dut_os  in  WIDTH  DUT result, valid DUT_LAT cycles after its i_valid.
- i_cmp_mask  in  WIDTH  1 = bit is compared; sampled at compare time.
- o_ready  out  1  warm-up complete.
- o_event  out  1  one-cycle mismatch pulse.
- o_err_sticky  out  1  at least one mismatch since reset or clear.
- o_chk_cnt  out  CNT_WIDTH  number of compares performed, saturating.
- o_err_cnt  out  CNT_WIDTH  number of mismatches, saturating.
- o_first_idx  out  CNT_WIDTH  o_chk_cnt value at the first mismatch.
- o_first_a / o_first_b / o_first_dut / o_first_exp  out  WIDTH each  context of the first mismatch.

Behaviour:
- Reset (reset_n low at a clock edge):
  - All outputs go to 0.
  - The delay line valid bits are cleared and the warm-up counter goes to 0.
  - This applies mid-operation too: in-flight samples are discarded and never checked.
- Delay line:
  - DUT_LAT stages, each holding {vld, a, b}.
  - Stage 0 loads vld = i_valid & i_en & o_ready_pre, where o_ready_pre is the warm-up-done flag.
  - The line shifts every cycle and has no stall.
- Warm-up:
  - The counter increments from reset until it reaches DUT_LAT+1, then holds.
  - o_ready = (counter == DUT_LAT+1).
  - Samples with i_valid before o_ready_pre is set are not checked.
- Compare stage, on the cycle the tap stage has vld = 1:
  - exp = f_MODE(a, b).
  - mis = |((i_dut_os ^ exp) & i_cmp_mask).
  - Results are registered.
- Latency: i_valid at cycle T → compare at T+DUT_LAT → o_event, counter and capture updates visible at T+DUT_LAT+1.
- Updates per compare:
  - o_chk_cnt += 1.
  - If mis: o_event = 1 for one cycle, o_err_cnt += 1, o_err_sticky = 1.
  - If mis and o_err_sticky was 0: capture a, b, i_dut_os, exp and the pre-increment o_chk_cnt into the o_first_* registers.
  - Capture is frozen until reset or clear.
- Saturation: both counters stop at 2^CNT_WIDTH-1 with no wrap. Compares continue, and o_event still pulses after saturation.
- Mask edge case: i_cmp_mask = 0 means every compare counts as a check and none can mismatch.
- i_clear:
  - Next cycle, counters, sticky and o_first_* read 0.
  - Clear wins over a compare in the same cycle; that compare is dropped entirely, including its o_event.
  - The delay line and warm-up state are unaffected.
- i_en toggling: i_en gates only at stage 0. Samples already in flight are still checked after i_en falls.
- Back-to-back valid every cycle is supported. Throughput is one check per cycle.
- Arithmetic:
  - Subtraction is two's complement mod 2^WIDTH.
  - Multiply uses an unsigned full product truncated to WIDTH.

Test Plan:
- Reset/warm-up: DUT_LAT=2, hold reset_n low 3 cycles, then valid every cycle from the first cycle after release → o_ready rises on the 3rd cycle after release; samples before that are not counted; all outputs read 0 during reset.
- Clean stream: MODE=0, WIDTH=8, 10 samples, a=i, b=2i, DUT correct → o_chk_cnt=10, o_err_cnt=0, o_event never high.
- First-error capture: MODE=0, WIDTH=8, 3rd sample a=0xFF, b=0x02, DUT returns 0x02 (expected 0x01), 5th sample also wrong → o_event at T+DUT_LAT+1 for each; o_err_cnt=2; o_first_idx=2, o_first_a=0xFF, o_first_b=0x02, o_first_dut=0x02, o_first_exp=0x01.
- Mask: MODE=1, WIDTH=8, a=0x10, b=0x20, DUT returns 0xF1 (expected 0xF0), mask=0xFE → no event; same stimulus with mask=0xFF → event.
- Clear collision: assert i_clear in the same cycle as a mismatching compare → next cycle all stats 0, no o_event; the following mismatch is captured as first, with o_first_idx=0.
- Saturation plus mid-run reset: CNT_WIDTH=4, 20 mismatches → o_err_cnt=15 and o_event keeps pulsing; then reset_n low with 2 samples in flight → those samples are never reported, and warm-up restarts.
